// File: rtl/shift_seq_ctrl.sv
// Iterative shift sequencer for the EX stage. It executes SLL/SRL/SRA and their variable
// forms at up to STEP bit positions per clock, stalls via busy and pulses done with the result.
module shift_seq_ctrl #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [5:0]  Signal,
  input  logic [31:0] in,
  input  logic [31:0] shamt,
  output logic [31:0] out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2
  } op_e;

  localparam logic [4:0] STEP_W = 5'(STEP);

  // Bit 2 flags a supported funct; bits 1:0 carry the shift kind.
  function automatic logic [2:0] decode_op(input logic [5:0] funct);
    logic [2:0] res;
    case (funct)
      6'b000000, 6'b000100: res = {1'b1, OP_SLL};
      6'b000010, 6'b000110: res = {1'b1, OP_SRL};
      6'b000011, 6'b000111: res = {1'b1, OP_SRA};
      default:              res = {1'b0, OP_SLL};
    endcase
    return res;
  endfunction

  function automatic logic [31:0] shift_step(input logic [31:0] d, input op_e op,
                                             input logic s, input logic [4:0] amt);
    logic [31:0] fill;
    logic [31:0] res;
    fill = s ? ~(32'hFFFF_FFFF >> amt) : 32'h0000_0000;
    case (op)
      OP_SLL:  res = d << amt;
      OP_SRL:  res = d >> amt;
      OP_SRA:  res = (d >> amt) | fill;
      default: res = d;
    endcase
    return res;
  endfunction

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [4:0]  step_s;
  logic [2:0]  dec_s;
  logic [31:0] shifted_s;
  logic        unused_shamt_s;

  assign unused_shamt_s = ^shamt[31:5];
  assign dec_s          = decode_op(Signal);
  assign step_s         = (cnt_q < STEP_W) ? cnt_q : STEP_W;
  assign shifted_s      = shift_step(data_q, op_q, sign_q, step_s);

  // Next-state and datapath update; flush overrides everything except reset.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sign_d  = sign_q;
    err_d   = err_q;
    if (flush) begin
      state_d = ST_IDLE;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            data_d = in;
            cnt_d  = shamt[4:0];
            op_d   = op_e'(dec_s[1:0]);
            sign_d = in[31];
            err_d  = ~dec_s[2];
            if (!dec_s[2] || (shamt[4:0] == 5'd0)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_SHIFT;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          data_d = shifted_s;
          cnt_d  = cnt_q - step_s;
          if (cnt_d == 5'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_SLL;
      data_q  <= 32'h0000_0000;
      cnt_q   <= 5'd0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = data_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: directed cases plus randomized ops,
// flushes, ignored starts and mid-operation resets against a behavioural model.
module tb_shift_seq_ctrl;
  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [5:0]  sig;
  logic [31:0] in_v;
  logic [31:0] shamt_v;
  logic [31:0] out_s;
  logic        busy_s;
  logic        done_s;
  logic        err_s;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          exp_edge;
    int          busy_len;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  logic [5:0] codes [6] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111};

  shift_seq_ctrl #(.STEP(STEP)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .Signal(sig),
    .in(in_v), .shamt(shamt_v), .out(out_s), .busy(busy_s), .done(done_s), .err(err_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Reference: result from plain shift operators, latency from ceil(n/STEP).
  function automatic exp_t model(input logic [5:0] f, input logic [31:0] a,
                                 input logic [31:0] sh, input int acc);
    exp_t e;
    int   n;
    int   k;
    n = int'(sh[4:0]);
    k = (n + STEP - 1) / STEP;
    e.err = 1'b0;
    case (f)
      6'b000000, 6'b000100: e.res = a << n;
      6'b000010, 6'b000110: e.res = a >> n;
      6'b000011, 6'b000111: e.res = $signed(a) >>> n;
      default: begin
        e.res = a;
        e.err = 1'b1;
        k = 0;
      end
    endcase
    e.exp_edge = acc + k;
    e.busy_len = k + 1;
    return e;
  endfunction

  task automatic wait_edge(input int target);
    while (edge_cnt < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: plain op; 1: extra start at edge acc+pos; 2: flush at edge acc+pos; 3: reset after edge acc+pos
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] sh,
                       input int mode, input int pos);
    exp_t e;
    int   acc;
    acc = edge_cnt + 1;
    e = model(f, a, sh, acc);
    if (mode <= 1) sb_q.push_back(e);
    sig = f; in_v = a; shamt_v = sh; start = 1'b1;
    if (mode == 2 && pos == 0) flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    sig = 6'($urandom); in_v = $urandom; shamt_v = $urandom;
    case (mode)
      1: begin
        wait_edge(acc + pos - 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_edge(acc + e.busy_len);
      end
      2: begin
        if (pos > 0) begin
          wait_edge(acc + pos - 1);
          flush = 1'b1;
          @(posedge clk); #1;
          flush = 1'b0;
        end
        check("flush_busy", {31'b0, busy_s}, 32'd0);
        check("flush_done", {31'b0, done_s}, 32'd0);
        check("flush_err", {31'b0, err_s}, 32'd0);
      end
      3: begin
        wait_edge(acc + pos);
        #1 reset = 1'b0;
        #1;
        check("rst_out", out_s, 32'h0000_0000);
        check("rst_busy", {31'b0, busy_s}, 32'd0);
        check("rst_done", {31'b0, done_s}, 32'd0);
        check("rst_err", {31'b0, err_s}, 32'd0);
        @(posedge clk); #1;
        #2 reset = 1'b1;
      end
      default: wait_edge(acc + e.busy_len);
    endcase
  endtask

  // Monitor: pops an expectation on every done pulse and flags missing pulses.
  initial begin : monitor
    exp_t e;
    int   busy_run;
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_run = 0;
      end else begin
        if (busy_s) busy_run++;
        else busy_run = 0;
        if (done_s) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done=1 expected done=0 (edge %0d)", edge_cnt);
          end else begin
            e = sb_q.pop_front();
            check("out", out_s, e.res);
            check("err", {31'b0, err_s}, {31'b0, e.err});
            check("done_edge", edge_cnt, e.exp_edge);
            check("busy_len", busy_run, e.busy_len);
          end
        end
        if (sb_q.size() > 0 && edge_cnt > sb_q[0].exp_edge) begin
          checks++; errors++;
          $display("FAIL done_timeout: got no done expected done at edge %0d", sb_q[0].exp_edge);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin : driver
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] sh;
    int          mode;
    int          k;
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    sig = 6'd0; in_v = 32'd0; shamt_v = 32'd0;
    #1 reset = 1'b0;
    #1;
    check("reset_out", out_s, 32'h0000_0000);
    check("reset_busy", {31'b0, busy_s}, 32'd0);
    check("reset_done", {31'b0, done_s}, 32'd0);
    check("reset_err", {31'b0, err_s}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;

    do_op(6'b000000, 32'h0000_0001, 32'd13, 0, 0);
    do_op(6'b000011, 32'h8000_0000, 32'd31, 0, 0);
    do_op(6'b000010, 32'h8000_0000, 32'd31, 0, 0);
    do_op(6'b000110, 32'hF000_0000, 32'h0000_0024, 0, 0);
    do_op(6'b000000, 32'hDEAD_BEEF, 32'd0, 0, 0);
    do_op(6'b100000, 32'h1234_5678, 32'd5, 0, 0);
    do_op(6'b000000, 32'h0000_0001, 32'd31, 0, 0);
    do_op(6'b000000, 32'h0000_0001, 32'd20, 1, 2);
    do_op(6'b000000, 32'h0000_0001, 32'd20, 2, 3);
    do_op(6'b000000, 32'h0000_0001, 32'd20, 2, 0);
    do_op(6'b000000, 32'h0000_0001, 32'd20, 3, 2);
    do_op(6'b000000, 32'h0000_0001, 32'd20, 0, 0);

    for (int i = 0; i < 300; i++) begin
      f    = ($urandom_range(0, 7) < 6) ? codes[$urandom_range(0, 5)] : 6'($urandom);
      a    = $urandom;
      sh   = $urandom;
      k    = model(f, a, sh, 0).busy_len - 1;
      mode = $urandom_range(0, 9);
      if (mode < 6) do_op(f, a, sh, 0, 0);
      else if (mode < 8) do_op(f, a, sh, 1, $urandom_range(1, k + 1));
      else if (mode < 9) do_op(f, a, sh, 2, $urandom_range(0, k));
      else do_op(f, a, sh, 3, $urandom_range(0, k));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (4) begin
      @(posedge clk); #1;
    end
    check("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Multi-cycle shift sequencer for the EX stage of the pipelined MIPS core. It replaces the single-cycle 32-bit barrel shifter on area-constrained builds. It accepts one shift operation (SLL/SRL/SRA and the variable forms), performs it iteratively at up to STEP bit positions per clock, and stalls the pipeline while busy. It produces a registered result with a one-cycle done pulse, and sits between ID/EX decode and the EX result mux.

## Interface
- STEP, default 4: maximum bit positions shifted per clock; legal range 1..31.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- flush  input  1  synchronous abort from hazard unit; highest priority after reset.
- Signal  input  6  funct code: SLL 000000, SRL 000010, SRA 000011, SLLV 000100, SRLV 000110, SRAV 000111.
- in  input  32  operand to shift (rt).
- shamt  input  32  shift amount; only shamt[4:0] is used, upper bits ignored. Upstream selects the instruction shamt field or rs.
- out  output  32  result register.
- busy  output  1  high while state is SHIFT or DONE; drives pipeline stall.
- done  output  1  one-cycle pulse; out is valid in the same cycle.
- err  output  1  set with done when Signal is unsupported.

## Operation
- States: IDLE, SHIFT, DONE. Registers: data[31:0], cnt[4:0], op[1:0] (left/logical-right/arith-right), sign, err.
- IDLE with start=1 at a rising edge:
  - Latch data=in, cnt=shamt[4:0], op decoded from Signal, sign=in[31], err=(Signal unsupported).
  - Go to DONE if err, or if cnt==0; otherwise go to SHIFT.
- SHIFT, each edge:
  - step = min(cnt, STEP).
  - data shifts by step: left fills 0; logical right fills 0; arithmetic right fills sign.
  - cnt -= step; when the new cnt==0, next state is DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. out continuously equals data.
- Unsupported Signal: data is not shifted, so out equals in, err=1, done=1.
- start outside IDLE is ignored; it is neither queued nor recorded.
- flush=1 at an edge in any state:
  - Next state is IDLE; done is not asserted; err is cleared.
  - data is left unchanged.
  - If flush and start arrive together in IDLE, flush wins and the start is dropped.
- Reset (asserted low, any time, including mid-operation):
  - State IDLE; data=0; cnt=0; err=0.
  - out=0, busy=0, done=0 immediately, without waiting for a clock edge.
- Width rules:
  - Shifts never exceed 31 positions total, so no bit-width overflow occurs.
  - cnt never underflows because step ≤ cnt.
  - A result shifted by 31 is exact: SRA of a negative value gives all ones; SLL of 1 gives 0x8000_0000.

## Timing
- Let n=shamt[4:0] and k=ceil(n/STEP), with edge 0 being the edge that accepts start.
- n==0 or unsupported Signal: DONE is entered at edge 0. done and busy are high in the cycle after edge 0, and the block is IDLE after edge 1.
- n>0: SHIFT covers edges 1..k and DONE is entered at edge k. done is high in the cycle after edge k; IDLE follows edge k+1.
- busy rises in the cycle after edge 0 and falls in the cycle after the done cycle.
- The earliest next start is accepted at the edge that ends the done cycle's successor, i.e. in the first IDLE cycle.
- out holds its value until the next accepted start updates data at that edge.
- There is no combinational path from inputs to outputs; all outputs are register- or state-decoded.

## Test plan
- Reset then SLL, in=0x0000_0001, shamt=13, STEP=4:
  - done in the cycle after edge 4, out=0x0000_2000, err=0.
  - busy high for exactly 5 cycles.
- SRA, in=0x8000_0000, shamt=31, STEP=4:
  - done after edge 8, out=0xFFFF_FFFF.
  - Repeat with SRL: out=0x0000_0001.
- SRLV, in=0xF000_0000, shamt=0x0000_0024 (upper bits ignored, n=4): done after edge 1, out=0x0F00_0000.
- shamt=0 with SLL, in=0xDEAD_BEEF: done in the cycle after the accept edge, out=0xDEAD_BEEF.
- Signal=100000, in=0x1234_5678: done=1 and err=1 after edge 0, out=0x1234_5678.
- Aborts and ignored starts (SLL n=20):
  - Pulse start again at edge 2: it is ignored and the result is still 0x0010_0000 for in=1 at edge 5.
  - Separate run with flush at edge 3: IDLE next cycle, no done pulse.
  - Separate run with reset asserted low at edge 2: out=0 and busy=0 immediately.
